// File: rtl/usb_tx_pkt_if.sv
// Request/status handshake between the device controller and the USB packet transmitter.
interface usb_tx_pkt_if;
  logic        tx_start;
  logic [3:0]  tx_pid;
  logic [63:0] tx_data;
  logic [3:0]  tx_nbytes;
  logic        tx_busy;
  logic        tx_done;
  logic        tx_err;

  modport master (
    output tx_start, tx_pid, tx_data, tx_nbytes,
    input  tx_busy, tx_done, tx_err
  );

  modport slave (
    input  tx_start, tx_pid, tx_data, tx_nbytes,
    output tx_busy, tx_done, tx_err
  );
endinterface

// File: rtl/usb_tx_pkt.sv
// USB full-speed device packet transmitter: SYNC, PID, payload, CRC16, bit stuffing,
// NRZI and EOP for handshake and DATA0/DATA1 packets.
module usb_tx_pkt #(
  parameter int unsigned BIT_PERIOD = 8,
  parameter int unsigned MAX_BYTES  = 8
) (
  input  logic          clk,
  input  logic          n_rst,
  usb_tx_pkt_if.slave   tx,
  output logic          tx_oe,
  output logic          d_plus,
  output logic          d_minus
);

  localparam int unsigned   CW       = (BIT_PERIOD > 2) ? $clog2(BIT_PERIOD) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BIT_PERIOD - 1);

  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_STALL = 4'b1110;

  typedef enum logic [2:0] {IDLE, SYNC, PID, DATA, CRC, EOP_SE0, EOP_J, DONE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [3:0]    idx;
  logic [3:0]    byte_cnt;
  logic [3:0]    nbytes_q;
  logic [3:0]    pid_q;
  logic [63:0]   data_sr;
  logic [15:0]   crc;
  logic [2:0]    ones;
  logic          line;
  logic          busy;
  logic          done;
  logic          err;

  logic          req_ok;
  logic          is_data;
  logic [7:0]    pid_byte;
  logic [2:0]    pid_nxt;
  logic          stuff;
  state_t        adv_state;
  logic [3:0]    adv_idx;
  logic [3:0]    adv_byte;
  logic          adv_bit;
  logic          adv_crc;

  assign tx.tx_busy = busy;
  assign tx.tx_done = done;
  assign tx.tx_err  = err;

  function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic b);
    return (c[0] ^ b) ? ((c >> 1) ^ 16'hA001) : (c >> 1);
  endfunction

  always_comb begin
    req_ok = 1'b0;
    unique case (tx.tx_pid)
      PID_ACK, PID_NAK, PID_STALL: req_ok = 1'b1;
      PID_DATA0, PID_DATA1:        req_ok = (32'(tx.tx_nbytes) <= MAX_BYTES);
      default:                     req_ok = 1'b0;
    endcase
  end

  // Position of the next raw bit; a pending stuff bit overrides this and leaves position untouched.
  always_comb begin
    is_data   = (pid_q == PID_DATA0) || (pid_q == PID_DATA1);
    pid_byte  = {~pid_q, pid_q};
    pid_nxt   = idx[2:0] + 3'd1;
    stuff     = (ones == 3'd6) && (state inside {SYNC, PID, DATA, CRC});
    adv_state = state;
    adv_idx   = idx + 4'd1;
    adv_byte  = byte_cnt;
    adv_bit   = 1'b0;
    adv_crc   = 1'b0;
    case (state)
      SYNC: begin
        if (idx != 4'd7) begin
          adv_bit = (idx == 4'd6);
        end else begin
          adv_state = PID;
          adv_idx   = '0;
          adv_bit   = pid_byte[0];
        end
      end
      PID: begin
        if (idx != 4'd7) begin
          adv_bit = pid_byte[pid_nxt];
        end else if (!is_data) begin
          adv_state = EOP_SE0;
          adv_idx   = '0;
        end else if (nbytes_q != 4'd0) begin
          adv_state = DATA;
          adv_idx   = '0;
          adv_byte  = '0;
          adv_bit   = data_sr[0];
          adv_crc   = 1'b1;
        end else begin
          adv_state = CRC;
          adv_idx   = '0;
          adv_bit   = ~crc[0];
        end
      end
      DATA: begin
        if (idx != 4'd7) begin
          adv_bit = data_sr[0];
          adv_crc = 1'b1;
        end else if ((byte_cnt + 4'd1) != nbytes_q) begin
          adv_idx  = '0;
          adv_byte = byte_cnt + 4'd1;
          adv_bit  = data_sr[0];
          adv_crc  = 1'b1;
        end else begin
          adv_state = CRC;
          adv_idx   = '0;
          adv_bit   = ~crc[0];
        end
      end
      CRC: begin
        if (idx != 4'd15) begin
          adv_bit = ~crc[idx + 4'd1];
        end else begin
          adv_state = EOP_SE0;
          adv_idx   = '0;
        end
      end
      EOP_SE0: begin
        if (idx == 4'd1) adv_state = EOP_J;
      end
      EOP_J:   adv_state = DONE;
      default: adv_state = state;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state    <= IDLE;
      cnt      <= '0;
      idx      <= '0;
      byte_cnt <= '0;
      nbytes_q <= '0;
      pid_q    <= '0;
      data_sr  <= '0;
      crc      <= '1;
      ones     <= '0;
      line     <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      tx_oe    <= 1'b0;
      d_plus   <= 1'b1;
      d_minus  <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (tx.tx_start) begin
            if (req_ok) begin
              state    <= SYNC;
              pid_q    <= tx.tx_pid;
              data_sr  <= tx.tx_data;
              nbytes_q <= tx.tx_nbytes;
              cnt      <= '0;
              idx      <= '0;
              byte_cnt <= '0;
              crc      <= '1;
              ones     <= '0;
              busy     <= 1'b1;
              tx_oe    <= 1'b1;
              // First SYNC bit is a raw 0: toggle from J to K.
              line     <= 1'b0;
              d_plus   <= 1'b0;
              d_minus  <= 1'b1;
            end else begin
              err <= 1'b1;
            end
          end
        end
        DONE: state <= IDLE;
        default: begin
          if (cnt != CNT_LAST) begin
            cnt <= cnt + 1'b1;
          end else begin
            cnt <= '0;
            if (stuff) begin
              ones    <= '0;
              line    <= ~line;
              d_plus  <= ~line;
              d_minus <= line;
            end else begin
              state    <= adv_state;
              idx      <= adv_idx;
              byte_cnt <= adv_byte;
              case (adv_state)
                EOP_SE0: begin
                  d_plus  <= 1'b0;
                  d_minus <= 1'b0;
                end
                EOP_J: begin
                  line    <= 1'b1;
                  d_plus  <= 1'b1;
                  d_minus <= 1'b0;
                end
                DONE: begin
                  tx_oe <= 1'b0;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                end
                default: begin
                  ones    <= adv_bit ? ones + 3'd1 : '0;
                  line    <= adv_bit ? line : ~line;
                  d_plus  <= adv_bit ? line : ~line;
                  d_minus <= adv_bit ? ~line : line;
                  if (adv_crc) begin
                    crc     <= crc16_step(crc, adv_bit);
                    data_sr <= {1'b0, data_sr[63:1]};
                  end
                end
              endcase
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_usb_tx_pkt.sv
// Directed self-checking bench for usb_tx_pkt: captures the line per bit time and
// compares against hand-derived patterns and a bit-level packet builder.
module tb_usb_tx_pkt;
  localparam int BP = 8;
  localparam logic [1:0] J = 2'b10, K = 2'b01, S0 = 2'b00;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  logic tx_oe, d_plus, d_minus;
  int checks = 0;
  int errors = 0;

  logic [1:0] cap_syms[$];
  logic [1:0] exp_syms[$];
  int         cap_done_idx, cap_unstable, cap_bad_ctrl, cap_err;
  logic [1:0] cap_done_lines;
  logic       cap_done_oe, cap_done_busy;

  usb_tx_pkt_if txi();

  usb_tx_pkt #(.BIT_PERIOD(BP), .MAX_BYTES(8)) dut (
    .clk(clk), .n_rst(n_rst), .tx(txi.slave),
    .tx_oe(tx_oe), .d_plus(d_plus), .d_minus(d_minus)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic run_pkt(input logic [3:0] pid, input logic [63:0] data, input logic [3:0] n);
    logic [1:0] s;
    @(negedge clk);
    txi.tx_start = 1'b1; txi.tx_pid = pid; txi.tx_data = data; txi.tx_nbytes = n;
    @(negedge clk);
    txi.tx_start = 1'b0;
    cap_syms.delete();
    cap_done_idx = -1; cap_unstable = 0; cap_bad_ctrl = 0; cap_err = 0;
    for (int i = 0; i < 4000; i++) begin
      s = {d_plus, d_minus};
      if (txi.tx_done === 1'b1) begin
        cap_done_idx = i; cap_done_lines = s; cap_done_oe = tx_oe; cap_done_busy = txi.tx_busy;
        break;
      end
      if (i % BP == 0) cap_syms.push_back(s);
      else if (s !== cap_syms[cap_syms.size()-1]) cap_unstable++;
      if (tx_oe !== 1'b1 || txi.tx_busy !== 1'b1) cap_bad_ctrl++;
      if (txi.tx_err !== 1'b0) cap_err++;
      @(negedge clk);
    end
  endtask

  task automatic model_pkt(input logic [3:0] pid, input logic [63:0] data, input logic [3:0] n);
    logic raw[$];
    logic [7:0] pb;
    logic [15:0] crc, inv;
    logic lvl, bt;
    int ones;
    for (int i = 0; i < 8; i++) raw.push_back(i == 7);
    pb = {~pid, pid};
    for (int i = 0; i < 8; i++) raw.push_back(pb[i]);
    if (pid == 4'b0011 || pid == 4'b1011) begin
      crc = 16'hFFFF;
      for (int b = 0; b < int'(n); b++)
        for (int i = 0; i < 8; i++) begin
          bt = data[8*b+i];
          raw.push_back(bt);
          crc = (crc[0] ^ bt) ? ((crc >> 1) ^ 16'hA001) : (crc >> 1);
        end
      inv = ~crc;
      for (int i = 0; i < 16; i++) raw.push_back(inv[i]);
    end
    exp_syms.delete();
    lvl = 1'b1; ones = 0;
    foreach (raw[k]) begin
      if (!raw[k]) lvl = ~lvl;
      exp_syms.push_back(lvl ? J : K);
      ones = raw[k] ? ones + 1 : 0;
      if (ones == 6) begin
        lvl = ~lvl; exp_syms.push_back(lvl ? J : K); ones = 0;
      end
    end
    exp_syms.push_back(S0); exp_syms.push_back(S0); exp_syms.push_back(J);
  endtask

  function automatic int sym_diff();
    int d = 0;
    if (cap_syms.size() != exp_syms.size()) d++;
    for (int k = 0; k < cap_syms.size() && k < exp_syms.size(); k++)
      if (cap_syms[k] !== exp_syms[k]) d++;
    return d;
  endfunction

  task automatic test_reset();
    n_rst = 1'b0;
    txi.tx_start = 1'b0; txi.tx_pid = '0; txi.tx_data = '0; txi.tx_nbytes = '0;
    repeat (3) @(negedge clk);
    checks++; if (txi.tx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", txi.tx_busy); end
    checks++; if (txi.tx_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", txi.tx_done); end
    checks++; if (txi.tx_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", txi.tx_err); end
    checks++; if (tx_oe !== 1'b0) begin errors++; $display("FAIL reset_oe: got %b expected 0", tx_oe); end
    checks++; if ({d_plus, d_minus} !== J) begin errors++; $display("FAIL reset_lines: got %b expected %b", {d_plus, d_minus}, J); end
    n_rst = 1'b1;
  endtask

  task automatic test_ack();
    logic [1:0] ack_exp[19] = '{K,J,K,J,K,J,K,K, J,J,K,J,J,K,K,K, S0,S0,J};
    run_pkt(4'b0010, 64'h0, 4'd0);
    exp_syms.delete();
    foreach (ack_exp[k]) exp_syms.push_back(ack_exp[k]);
    checks++; if (cap_done_idx !== 19*BP) begin errors++; $display("FAIL ack_len: got %0d expected %0d", cap_done_idx, 19*BP); end
    checks++; if (sym_diff() !== 0) begin errors++; $display("FAIL ack_wire: %0d symbol differences", sym_diff()); end
    checks++; if (cap_bad_ctrl !== 0) begin errors++; $display("FAIL ack_busy_oe: got %0d low cycles expected 0", cap_bad_ctrl); end
    checks++; if (cap_unstable !== 0) begin errors++; $display("FAIL ack_midbit: got %0d mid-bit changes expected 0", cap_unstable); end
    checks++; if ({cap_done_oe, cap_done_busy, cap_done_lines} !== {1'b0, 1'b0, J})
      begin errors++; $display("FAIL ack_done_state: got oe/busy/lines %b expected 0010", {cap_done_oe, cap_done_busy, cap_done_lines}); end
    @(negedge clk);
    checks++; if (txi.tx_done !== 1'b0) begin errors++; $display("FAIL ack_done_pulse: got %b expected 0", txi.tx_done); end
  endtask

  task automatic test_data0_empty();
    int same = 0;
    run_pkt(4'b0011, 64'h0, 4'd0);
    model_pkt(4'b0011, 64'h0, 4'd0);
    checks++; if (cap_done_idx !== 35*BP) begin errors++; $display("FAIL d0e_len: got %0d expected %0d", cap_done_idx, 35*BP); end
    checks++; if (sym_diff() !== 0) begin errors++; $display("FAIL d0e_wire: %0d symbol differences", sym_diff()); end
    for (int k = 16; k < 32; k++) if (cap_syms[k] === cap_syms[k-1]) same++;
    checks++; if (same !== 0) begin errors++; $display("FAIL d0e_crc_toggle: got %0d held bits expected 0", same); end
  endtask

  task automatic test_data1_stuff();
    int held = 0;
    run_pkt(4'b1011, 64'hFF, 4'd1);
    model_pkt(4'b1011, 64'hFF, 4'd1);
    checks++; if (cap_done_idx !== exp_syms.size()*BP) begin errors++; $display("FAIL d1ff_len: got %0d expected %0d", cap_done_idx, exp_syms.size()*BP); end
    checks++; if (sym_diff() !== 0) begin errors++; $display("FAIL d1ff_wire: %0d symbol differences", sym_diff()); end
    for (int k = 16; k < 22; k++) if (cap_syms[k] !== cap_syms[15]) held++;
    checks++; if (held !== 0 || cap_syms[22] === cap_syms[21])
      begin errors++; $display("FAIL d1ff_stuff: got %0d changes in hold, stuff %b->%b expected toggle", held, cap_syms[21], cap_syms[22]); end
  endtask

  task automatic test_packets();
    logic [3:0]  pids[4]  = '{4'b1010, 4'b1110, 4'b0011, 4'b1011};
    logic [63:0] datas[4] = '{64'h0, 64'h0, 64'hFFFF_0080_7F00_FFC3, 64'h0000_0000_00A5_5AC3};
    logic [3:0]  ns[4]    = '{4'd0, 4'd0, 4'd8, 4'd3};
    for (int t = 0; t < 4; t++) begin
      run_pkt(pids[t], datas[t], ns[t]);
      model_pkt(pids[t], datas[t], ns[t]);
      checks++; if (cap_done_idx !== exp_syms.size()*BP) begin errors++; $display("FAIL pkt%0d_len: got %0d expected %0d", t, cap_done_idx, exp_syms.size()*BP); end
      checks++; if (sym_diff() !== 0 || cap_err !== 0) begin errors++; $display("FAIL pkt%0d_wire: %0d symbol differences, %0d err cycles", t, sym_diff(), cap_err); end
    end
  endtask

  task automatic test_errors();
    logic [3:0] pids[2] = '{4'b0001, 4'b0011};
    logic [3:0] ns[2]   = '{4'd0, 4'd9};
    for (int t = 0; t < 2; t++) begin
      @(negedge clk);
      txi.tx_start = 1'b1; txi.tx_pid = pids[t]; txi.tx_nbytes = ns[t];
      @(negedge clk);
      txi.tx_start = 1'b0;
      checks++; if ({txi.tx_err, txi.tx_busy, tx_oe, d_plus, d_minus} !== 5'b10010)
        begin errors++; $display("FAIL err%0d_flag: got err/busy/oe/lines %b expected 10010", t, {txi.tx_err, txi.tx_busy, tx_oe, d_plus, d_minus}); end
      @(negedge clk);
      checks++; if ({txi.tx_err, txi.tx_busy, tx_oe} !== 3'b000)
        begin errors++; $display("FAIL err%0d_pulse: got err/busy/oe %b expected 000", t, {txi.tx_err, txi.tx_busy, tx_oe}); end
    end
  endtask

  task automatic test_ignore_busy();
    fork
      run_pkt(4'b0011, 64'h0000_0000_0000_F00D, 4'd2);
      begin
        repeat (100) @(negedge clk);
        txi.tx_start = 1'b1; txi.tx_pid = 4'b0010; txi.tx_data = 64'hFFFF_FFFF_FFFF_FFFF; txi.tx_nbytes = 4'd5;
        @(negedge clk);
        txi.tx_start = 1'b0;
      end
    join
    model_pkt(4'b0011, 64'h0000_0000_0000_F00D, 4'd2);
    checks++; if (sym_diff() !== 0 || cap_done_idx !== exp_syms.size()*BP)
      begin errors++; $display("FAIL ignore_wire: %0d symbol differences, len %0d expected %0d", sym_diff(), cap_done_idx, exp_syms.size()*BP); end
    checks++; if (cap_err !== 0) begin errors++; $display("FAIL ignore_err: got %0d err cycles expected 0", cap_err); end
  endtask

  task automatic test_reset_mid();
    logic [1:0] ack_exp[19] = '{K,J,K,J,K,J,K,K, J,J,K,J,J,K,K,K, S0,S0,J};
    @(negedge clk);
    txi.tx_start = 1'b1; txi.tx_pid = 4'b0011; txi.tx_data = 64'h0123_4567_89AB_CDEF; txi.tx_nbytes = 4'd8;
    @(negedge clk);
    txi.tx_start = 1'b0;
    repeat (25*BP) @(negedge clk);
    #2 n_rst = 1'b0;
    #1;
    checks++; if ({tx_oe, d_plus, d_minus, txi.tx_busy} !== 4'b0100)
      begin errors++; $display("FAIL rstmid_abort: got oe/dp/dm/busy %b expected 0100", {tx_oe, d_plus, d_minus, txi.tx_busy}); end
    @(negedge clk);
    n_rst = 1'b1;
    run_pkt(4'b0010, 64'h0, 4'd0);
    exp_syms.delete();
    foreach (ack_exp[k]) exp_syms.push_back(ack_exp[k]);
    checks++; if (sym_diff() !== 0 || cap_done_idx !== 19*BP)
      begin errors++; $display("FAIL rstmid_ack: %0d symbol differences, len %0d expected %0d", sym_diff(), cap_done_idx, 19*BP); end
  endtask

  task automatic test_back_to_back();
    run_pkt(4'b1010, 64'h0, 4'd0);
    model_pkt(4'b1010, 64'h0, 4'd0);
    checks++; if (sym_diff() !== 0 || cap_done_idx !== 19*BP)
      begin errors++; $display("FAIL b2b_first: %0d symbol differences, len %0d expected %0d", sym_diff(), cap_done_idx, 19*BP); end
    run_pkt(4'b1011, 64'h0000_0000_0000_7EFE, 4'd2);
    model_pkt(4'b1011, 64'h0000_0000_0000_7EFE, 4'd2);
    checks++; if (sym_diff() !== 0 || cap_done_idx !== exp_syms.size()*BP)
      begin errors++; $display("FAIL b2b_second: %0d symbol differences, len %0d expected %0d", sym_diff(), cap_done_idx, exp_syms.size()*BP); end
  endtask

  initial begin
    test_reset();
    test_ack();
    test_data0_empty();
    test_data1_stuff();
    test_packets();
    test_errors();
    test_ignore_busy();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
